led7_segment: RTL and testbench
===============================

# led7_segment

Registered single-digit seven-segment decoder. Converts a 4-bit value (0–F) into segment drive pattern `seg` and a digit-enable strobe `dig` for one physical display digit. Sits between the numeric datapath and the board's LED pins. Supports lamp-test, blanking and configurable output polarity for common-cathode or common-anode parts.

## Interface

Parameters:

- `SEG_ACTIVE_LOW`, default 0. 0: segment lit when its `seg` bit is 1. 1: every `seg` bit is inverted at the output register.
- `DIG_ACTIVE_LOW`, default 0. 0: digit enabled when `dig` is 1. 1: `dig` is inverted at the output register.

Ports:

- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst_n`  in  1  Reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `num`  in  4  Value to display, 0–15.
- `blank`  in  1  1 forces all segments off and the digit disabled.
- `lamp_test`  in  1  1 forces all segments on and the digit enabled. Has priority over `blank` and `num`.
- `seg`  out  7  Segment drive. Bit 6 = a, 5 = b, 4 = c, 3 = d, 2 = e, 1 = f, 0 = g.
- `dig`  out  1  Digit enable, registered.

## Operation

Logical patterns (active-high, a..g, before polarity inversion):

- 0: 1111110
- 1: 0110000
- 2: 1101101
- 3: 1111001
- 4: 0110011
- 5: 1011011
- 6: 1011111
- 7: 1110000
- 8: 1111111
- 9: 1110011
- A: 1110111
- b: 0011111
- C: 1001110
- d: 0111101
- E: 1001111
- F: 1000111

All 16 codes are defined. There is no invalid or default case beyond these.

Priority, evaluated each cycle:

- `lamp_test` = 1: pattern 1111111, digit enabled.
- else `blank` = 1: pattern 0000000, digit disabled.
- else: decoded `num`, digit enabled.

Output polarity:

- `seg` = pattern XOR {7{SEG_ACTIVE_LOW}}.
- `dig` = enable XOR DIG_ACTIVE_LOW.

Outputs come directly from flops. There is no combinational path from inputs to outputs.

## Timing

- Reset: while `rst_n` = 0 at a rising edge, `seg` and `dig` load their physical "off" values on that edge.
  - `seg` = 0000000 (1111111 if SEG_ACTIVE_LOW).
  - `dig` = 0 (1 if DIG_ACTIVE_LOW).
- Reset wins over `lamp_test`, `blank` and `num`.
- Latency: exactly 1 clock. Inputs sampled at edge N appear on `seg`/`dig` after edge N and hold until edge N+1.
- The first edge with `rst_n` = 1 loads the decoded value. No warm-up cycles.
- Input changes between edges have no output effect until the next edge. Back-to-back changes every cycle are each reflected one cycle later.
- Reset asserted mid-stream forces "off" on the next edge regardless of inputs. The previous value is not retained after reset.
- Simultaneous `lamp_test` and `blank`: lamp-test result.

## Test plan

- Reset: hold `rst_n` = 0 for 2 edges with `num` = 8 and `lamp_test` = 1 -> `seg` = 0000000, `dig` = 0. Release; 1 edge later with `lamp_test` = 0 -> `seg` = 1111111, `dig` = 1.
- Decimal sweep: `num` = 0..9, one per cycle, blank = lamp_test = 0 -> each pattern one cycle later.
  - 0 -> 1111110, 1 -> 0110000, 2 -> 1101101, 3 -> 1111001, 4 -> 0110011.
  - 5 -> 1011011, 6 -> 1011111, 7 -> 1110000, 8 -> 1111111, 9 -> 1110011.
  - `dig` = 1 throughout.
- Hex sweep: `num` = 10..15 -> 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
- Priority: `num` = 1 with `blank` = 1 -> `seg` = 0000000, `dig` = 0. Then add `lamp_test` = 1 -> `seg` = 1111111, `dig` = 1. Then drop both -> `seg` = 0110000.
- Polarity: build with SEG_ACTIVE_LOW = 1, DIG_ACTIVE_LOW = 1.
  - `num` = 0 -> `seg` = 0000001, `dig` = 0.
  - Under reset -> `seg` = 1111111, `dig` = 1.
- Latency: change `num` 3 -> 7 immediately after an edge -> `seg` remains 1111001 until the next edge, then 1110000.

Source files
------------

// File: rtl/led7_segment_if.sv
// Display-side signal bundle for led7_segment: digit value and override controls in,
// registered segment/digit drive out.
interface led7_segment_if;
    logic [3:0] num;
    logic       blank;
    logic       lamp_test;
    logic [6:0] seg;
    logic       dig;

    modport master (
        output num,
        output blank,
        output lamp_test,
        input  seg,
        input  dig
    );

    modport slave (
        input  num,
        input  blank,
        input  lamp_test,
        output seg,
        output dig
    );
endinterface

// File: rtl/led7_segment.sv
// Registered single-digit hex seven-segment decoder with lamp-test, blanking and
// selectable segment/digit polarity. Outputs come straight from flops.
module led7_segment #(
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    led7_segment_if.slave bus
);

    localparam logic [6:0] SegOff = {7{SEG_ACTIVE_LOW}};
    localparam logic       DigOff = DIG_ACTIVE_LOW;

    logic [6:0] decoded;
    logic [6:0] pattern;
    logic       enable;
    logic [6:0] seg_q;
    logic       dig_q;

    // Active-high a..g pattern, bit 6 = a, bit 0 = g.
    always_comb begin
        decoded = 7'b0000000;
        unique case (bus.num)
            4'h0: decoded = 7'b1111110;
            4'h1: decoded = 7'b0110000;
            4'h2: decoded = 7'b1101101;
            4'h3: decoded = 7'b1111001;
            4'h4: decoded = 7'b0110011;
            4'h5: decoded = 7'b1011011;
            4'h6: decoded = 7'b1011111;
            4'h7: decoded = 7'b1110000;
            4'h8: decoded = 7'b1111111;
            4'h9: decoded = 7'b1110011;
            4'hA: decoded = 7'b1110111;
            4'hB: decoded = 7'b0011111;
            4'hC: decoded = 7'b1001110;
            4'hD: decoded = 7'b0111101;
            4'hE: decoded = 7'b1001111;
            4'hF: decoded = 7'b1000111;
        endcase
    end

    // Lamp-test beats blanking, which beats the decoded value.
    always_comb begin
        pattern = decoded;
        enable  = 1'b1;
        if (bus.lamp_test) begin
            pattern = 7'b1111111;
            enable  = 1'b1;
        end else if (bus.blank) begin
            pattern = 7'b0000000;
            enable  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SegOff;
            dig_q <= DigOff;
        end else begin
            seg_q <= pattern ^ {7{SEG_ACTIVE_LOW}};
            dig_q <= enable ^ DIG_ACTIVE_LOW;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dig = dig_q;

endmodule

// File: tb/tb_led7_segment.sv
// Directed bench for led7_segment: one active-high build and one active-low build
// driven by identical stimulus.
module tb_led7_segment;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    led7_segment_if if_hi ();
    led7_segment_if if_lo ();

    led7_segment #(
        .SEG_ACTIVE_LOW(1'b0),
        .DIG_ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_hi.slave)
    );

    led7_segment #(
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_lo.slave)
    );

    logic [6:0] pat [16];

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] n, input logic b, input logic lt);
        if_hi.num       = n;
        if_hi.blank     = b;
        if_hi.lamp_test = lt;
        if_lo.num       = n;
        if_lo.blank     = b;
        if_lo.lamp_test = lt;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101;
        pat[3]  = 7'b1111001; pat[4]  = 7'b0110011; pat[5]  = 7'b1011011;
        pat[6]  = 7'b1011111; pat[7]  = 7'b1110000; pat[8]  = 7'b1111111;
        pat[9]  = 7'b1110011; pat[10] = 7'b1110111; pat[11] = 7'b0011111;
        pat[12] = 7'b1001110; pat[13] = 7'b0111101; pat[14] = 7'b1001111;
        pat[15] = 7'b1000111;

        // Reset wins over lamp-test.
        rst_n = 1'b0;
        drive(4'd8, 1'b0, 1'b1);
        step();
        step();
        check("rst_seg_hi", if_hi.seg, 7'b0000000);
        check("rst_dig_hi", {6'd0, if_hi.dig}, 7'd0);
        check("rst_seg_lo", if_lo.seg, 7'b1111111);
        check("rst_dig_lo", {6'd0, if_lo.dig}, 7'd1);

        // First edge out of reset loads the decoded value.
        rst_n = 1'b1;
        drive(4'd8, 1'b0, 1'b0);
        step();
        check("post_rst_seg", if_hi.seg, 7'b1111111);
        check("post_rst_dig", {6'd0, if_hi.dig}, 7'd1);

        // Full 0..F sweep, one value per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(i[3:0], 1'b0, 1'b0);
            step();
            check($sformatf("sweep_hi_%0d", i), if_hi.seg, pat[i]);
            check($sformatf("sweep_dig_%0d", i), {6'd0, if_hi.dig}, 7'd1);
            check($sformatf("sweep_lo_%0d", i), if_lo.seg, ~pat[i]);
        end

        // Polarity spot check on num = 0.
        drive(4'd0, 1'b0, 1'b0);
        step();
        check("pol_seg_lo", if_lo.seg, 7'b0000001);
        check("pol_dig_lo", {6'd0, if_lo.dig}, 7'd0);

        // Priority: blank, then lamp-test over blank, then normal.
        drive(4'd1, 1'b1, 1'b0);
        step();
        check("blank_seg", if_hi.seg, 7'b0000000);
        check("blank_dig", {6'd0, if_hi.dig}, 7'd0);
        check("blank_dig_lo", {6'd0, if_lo.dig}, 7'd1);
        drive(4'd1, 1'b1, 1'b1);
        step();
        check("lamp_seg", if_hi.seg, 7'b1111111);
        check("lamp_dig", {6'd0, if_hi.dig}, 7'd1);
        check("lamp_seg_lo", if_lo.seg, 7'b0000000);
        drive(4'd1, 1'b0, 1'b0);
        step();
        check("unforce_seg", if_hi.seg, 7'b0110000);

        // Latency: a change between edges is invisible until the next edge.
        drive(4'd3, 1'b0, 1'b0);
        step();
        check("lat_3", if_hi.seg, 7'b1111001);
        drive(4'd7, 1'b0, 1'b0);
        #3;
        check("lat_hold", if_hi.seg, 7'b1111001);
        step();
        check("lat_7", if_hi.seg, 7'b1110000);

        // Mid-stream reset forces off; the old value is not retained.
        drive(4'd5, 1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        check("mid_rst_seg", if_hi.seg, 7'b0000000);
        check("mid_rst_dig", {6'd0, if_hi.dig}, 7'd0);
        check("mid_rst_seg_lo", if_lo.seg, 7'b1111111);
        rst_n = 1'b1;
        drive(4'd5, 1'b0, 1'b0);
        step();
        check("resume_seg", if_hi.seg, 7'b1011011);
        check("resume_dig", {6'd0, if_hi.dig}, 7'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
